// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC owner and IF/ID pipeline register
//
// Purpose
//   Sits directly upstream of instruction_memory.
//   - Holds the program counter and presents it as the word address to memory.
//   - Captures the same-cycle returned word into the IF/ID register for decode.
//   - Handles stall, flush and taken-branch redirect.
//   Optional performance counters are compiled in when the macro FETCH_PERF_EN
//   is defined.
//
// Parameters
//   RESET_PC       PC value loaded on reset (word address)
//   PC_STEP        PC increment per fetch (memory is word-addressed)
//   NOP_INSTR      bubble word placed in if_instr on reset, flush or redirect
//
// Ports
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   stall           in   1   hazard stall from decode; PC and IF/ID freeze
//   flush           in   1   discard current fetch, insert bubble, PC holds
//   branch_taken    in   1   redirect from execute
//   branch_target   in   32  redirect word address, used only with branch_taken
//   imem_addr       out  32  word address to instruction_memory (= pc)
//   imem_instr      in   32  instruction word returned combinationally
//   if_valid        out  1   IF/ID holds a real instruction
//   if_instr        out  32  IF/ID instruction
//   if_pc           out  32  IF/ID fetch address
//   if_pc_next      out  32  IF/ID fetch address + PC_STEP
//   perf_fetch_cnt  out  32  (FETCH_PERF_EN) count of edges that fetched
//   perf_bubble_cnt out  32  (FETCH_PERF_EN) count of stall/flush/redirect edges

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] PC_STEP   = 32'd1,
  parameter logic [31:0] NOP_INSTR = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_next
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  // Per-edge action, resolved in priority order: redirect > flush > stall > fetch.
  typedef enum logic [1:0] {
    ACT_FETCH    = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_FLUSH    = 2'd2,
    ACT_REDIRECT = 2'd3
  } fetch_act_e;

  fetch_act_e  act;

  logic [31:0] pc;
  logic [31:0] pc_plus;

  logic [31:0] pc_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] ifpc_d;
  logic [31:0] ifpc_next_d;

  // Memory sees the PC register directly; this is the only comb path to an output.
  assign imem_addr = pc;

  // Natural 32-bit wrap: 32'hFFFFFFFF + 1 -> 0.
  assign pc_plus = pc + PC_STEP;

  always_comb begin
    act = ACT_FETCH;
    if (branch_taken) begin
      act = ACT_REDIRECT;
    end else if (flush) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_STALL;
    end
  end

  always_comb begin
    pc_d        = pc;
    valid_d     = if_valid;
    instr_d     = if_instr;
    ifpc_d      = if_pc;
    ifpc_next_d = if_pc_next;
    unique case (act)
      ACT_REDIRECT: begin
        // if_pc/if_pc_next deliberately keep their old values under a bubble.
        pc_d    = branch_target;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      ACT_FLUSH: begin
        // PC holds so the discarded address is fetched again next cycle.
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      ACT_STALL: begin
      end
      ACT_FETCH: begin
        pc_d        = pc_plus;
        valid_d     = 1'b1;
        instr_d     = imem_instr;
        ifpc_d      = pc;
        ifpc_next_d = pc_plus;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= 32'd0;
      if_pc_next <= 32'd0;
    end else begin
      pc         <= pc_d;
      if_valid   <= valid_d;
      if_instr   <= instr_d;
      if_pc      <= ifpc_d;
      if_pc_next <= ifpc_next_d;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else if (act == ACT_FETCH) begin
      perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
    end else begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_instr;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_next;

  logic        z_stall, z_flush, z_br;
  logic [31:0] z_tgt;
  logic [31:0] w_addr, w_instr;
  logic        w_valid;
  logic [31:0] w_if_instr, w_if_pc, w_if_pc_next;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
  logic [31:0] w_perf_f, w_perf_b;
`endif

  always #5 clk = ~clk;

  // Memory model: word at address a is a + 0xA0.
  assign imem_instr = imem_addr + 32'hA0;
  assign w_instr    = w_addr + 32'hA0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(z_stall), .flush(z_flush),
    .branch_taken(z_br), .branch_target(z_tgt),
    .imem_addr(w_addr), .imem_instr(w_instr),
    .if_valid(w_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc_next(w_if_pc_next)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(w_perf_f), .perf_bubble_cnt(w_perf_b)
`endif
  );

  int passed = 0;
  int total  = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpcn;
  logic        m_valid;
  int unsigned m_fetches, m_bubbles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'd0; m_ifpcn = 32'd0;
    m_fetches = 0; m_bubbles = 0;
  endtask

  task automatic model_edge(input logic s, input logic f, input logic b, input logic [31:0] t);
    if (b) begin
      m_pc = t; m_valid = 1'b0; m_instr = NOP; m_bubbles++;
    end else if (f) begin
      m_valid = 1'b0; m_instr = NOP; m_bubbles++;
    end else if (s) begin
      m_bubbles++;
    end else begin
      m_instr = m_pc + 32'hA0; m_ifpc = m_pc; m_ifpcn = m_pc + 32'd1;
      m_valid = 1'b1; m_pc = m_pc + 32'd1; m_fetches++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"},  imem_addr,  m_pc);
    chk({tag, ".if_valid"},   {31'd0, if_valid}, {31'd0, m_valid});
    chk({tag, ".if_instr"},   if_instr,   m_instr);
    chk({tag, ".if_pc"},      if_pc,      m_ifpc);
    chk({tag, ".if_pc_next"}, if_pc_next, m_ifpcn);
`ifdef FETCH_PERF_EN
    chk({tag, ".perf_fetch"},  perf_fetch_cnt,  m_fetches);
    chk({tag, ".perf_bubble"}, perf_bubble_cnt, m_bubbles);
`endif
  endtask

  // Drive controls, take one edge, update model, check 1 time unit later.
  task automatic step(input logic s, input logic f, input logic b,
                      input logic [31:0] t, input string tag);
    stall = s; flush = f; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_edge(s, f, b, t);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic s, f, b;
    logic [31:0] t;

    rst_n = 1'b0; stall = 0; flush = 0; branch_taken = 0; branch_target = 32'h0;
    z_stall = 0; z_flush = 0; z_br = 0; z_tgt = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    chk("wrap.reset_addr", w_addr, 32'hFFFF_FFFF);
    rst_n = 1'b1;

    // Sequential fetch from 0.
    step(0, 0, 0, 32'h0, "seq1");
    chk("wrap.addr",    w_addr,       32'h0);
    chk("wrap.if_pc",   w_if_pc,      32'hFFFF_FFFF);
    chk("wrap.if_pcn",  w_if_pc_next, 32'h0);
    chk("wrap.instr",   w_if_instr,   32'h9F);
    chk("seq1.instr_const", if_instr, 32'hA0);
    step(0, 0, 0, 32'h0, "seq2");
    step(0, 0, 0, 32'h0, "seq3");
    chk("seq3.addr_const", imem_addr, 32'd3);

    // Stall two cycles at pc=3; branch_target garbage must be ignored.
    step(1, 0, 0, 32'hDEAD, "stall1");
    step(1, 0, 0, 32'hBEEF, "stall2");
    chk("stall2.if_pc_const", if_pc, 32'd2);
    step(0, 0, 0, 32'h0, "stall_rel");
    chk("stall_rel.if_pc_const", if_pc, 32'd3);

    // Redirect overrides simultaneous stall (and flush).
    step(1, 1, 1, 32'h10, "br_stall");
    chk("br_stall.addr_const", imem_addr, 32'h10);
    step(0, 0, 0, 32'h0, "br_after");
    chk("br_after.if_pcn_const", if_pc_next, 32'h11);

    // Flush alone at pc=5.
    step(0, 0, 1, 32'h5, "to5");
    step(0, 1, 0, 32'h0, "flush");
    chk("flush.addr_const", imem_addr, 32'd5);
    step(0, 0, 0, 32'h0, "flush_after");
    chk("flush_after.if_pc_const", if_pc, 32'd5);

    // Randomized control mix with occasional targets near the wrap point.
    for (int i = 0; i < 300; i++) begin
      b = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                      : $urandom;
      step(s, f, b, t, "rand");
    end

    // Asynchronous reset in mid-cycle: outputs clear before the next edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst_n = 1'b1;
    step(0, 0, 0, 32'h0, "post_rst1");
    step(0, 0, 0, 32'h0, "post_rst2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
